// File: rtl/posit_pkg.sv
// Shared definitions for the posit divider: default widths, FSM states and
// reference encodings for the default word width.
package posit_pkg;

   localparam int POSIT_N  = 16;
   localparam int POSIT_ES = 2;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      DIVIDE,
      ENCODE,
      DONE
   } state_e;

   localparam logic [POSIT_N-1:0] ZERO   = '0;
   localparam logic [POSIT_N-1:0] NAR    = {1'b1, {(POSIT_N-1){1'b0}}};
   localparam logic [POSIT_N-1:0] MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
   localparam logic [POSIT_N-1:0] MINPOS = {{(POSIT_N-1){1'b0}}, 1'b1};

   // Signed width that holds the difference of two extreme scales with margin.
   function automatic int scale_width(input int n, input int es);
      return $clog2(2 * (n - 2) * (1 << es) + (1 << es) + 2) + 2;
   endfunction

endpackage

// File: rtl/posit_decode.sv
// Splits a posit word into sign, scale and a hidden-one mantissa, and flags
// the zero and NaR encodings.
module posit_decode
   import posit_pkg::*;
#(
   parameter int N  = POSIT_N,
   parameter int ES = POSIT_ES,
   parameter int SW = scale_width(N, ES)
) (
   input  logic [N-1:0]         word_i,
   output logic                 sign_o,
   output logic signed [SW-1:0] scale_o,
   output logic [N-1:0]         mant_o,
   output logic                 isZero_o,
   output logic                 isNar_o
);

   logic [N-2:0]  rem;
   logic [N-2:0]  shifted;
   logic [ES-1:0] expBits;
   logic          stop;
   int            runLen;
   int            kVal;

   // The regime run is counted from the first bit after the sign; whatever the
   // regime leaves behind is exponent then fraction, zero-filled on the right.
   always_comb begin
      rem    = word_i[N-1] ? (N-1)'(-word_i) : word_i[N-2:0];
      runLen = 1;
      stop   = 1'b0;
      for (int i = N - 3; i >= 0; i--) begin
         if (!stop) begin
            if (rem[i] == rem[N-2]) runLen = runLen + 1;
            else stop = 1'b1;
         end
      end
      kVal     = rem[N-2] ? runLen - 1 : -runLen;
      shifted  = rem << (runLen + 1);
      expBits  = shifted[N-2 -: ES];
      mant_o   = {1'b1, shifted[N-2-ES:0], {ES{1'b0}}};
      scale_o  = SW'(kVal * (2 ** ES) + int'(expBits));
      sign_o   = word_i[N-1];
      isZero_o = (word_i == '0);
      isNar_o  = (word_i == {1'b1, {(N-1){1'b0}}});
   end

endmodule

// File: rtl/posit_divider.sv
// Multi-cycle posit divider: decode, restoring mantissa division one bit per
// cycle, then re-encode with truncation and magnitude saturation.
module posit_divider
   import posit_pkg::*;
#(
   parameter int N  = POSIT_N,
   parameter int ES = POSIT_ES
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] q,
   output logic         div_by_zero
);

   localparam int SW = scale_width(N, ES);
   localparam int CW = $clog2(N + 1);
   localparam int L  = 2 * N + ES;

   localparam logic [N-1:0] NarWord    = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] MaxPosWord = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MinPosWord = {{(N-1){1'b0}}, 1'b1};
   localparam logic signed [SW-1:0] MaxScale = SW'((N - 2) * (2 ** ES));
   localparam logic signed [SW-1:0] MinScale = -MaxScale;

   state_e state_q, state_d;
   logic [N-1:0]         a_q, a_d, b_q, b_d;
   logic                 sign_q, sign_d;
   logic signed [SW-1:0] scale_q, scale_d;
   logic [N:0]           rem_q, rem_d;
   logic [N-1:0]         div_q, div_d;
   logic [N:0]           quot_q, quot_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 nar_q, nar_d, zero_q, zero_d, dz_q, dz_d;
   logic [N-1:0]         res_q, res_d;
   logic                 resDz_q, resDz_d;

   logic                 aSign, bSign, aZero, bZero, aNar, bNar;
   logic signed [SW-1:0] aScale, bScale;
   logic [N-1:0]         aMant, bMant;

   posit_decode #(.N(N), .ES(ES), .SW(SW)) decodeA (
      .word_i(a_q), .sign_o(aSign), .scale_o(aScale), .mant_o(aMant),
      .isZero_o(aZero), .isNar_o(aNar)
   );

   posit_decode #(.N(N), .ES(ES), .SW(SW)) decodeB (
      .word_i(b_q), .sign_o(bSign), .scale_o(bScale), .mant_o(bMant),
      .isZero_o(bZero), .isNar_o(bNar)
   );

   logic                 geq;
   logic [N-1:0]         remSub;

   // One restoring-division step: subtract when possible, then shift.
   always_comb begin
      geq    = (rem_q >= {1'b0, div_q});
      remSub = geq ? N'(rem_q - {1'b0, div_q}) : rem_q[N-1:0];
   end

   logic signed [SW-1:0] sNorm, kVal;
   logic [SW-1:0]        runLen;
   logic [ES-1:0]        eBits;
   logic [N-1:0]         fracN, magWord, encoded;
   logic                 term;
   logic [L-1:0]         bufWord, shifted;
   logic [N-2:0]         body;

   // Regime, exponent and fraction are laid out behind a terminator bit and
   // shifted right by the run length, filling with the regime bit; whatever
   // falls off the bottom is truncated.
   always_comb begin
      fracN   = quot_q[N] ? quot_q[N-1:0] : {quot_q[N-2:0], 1'b0};
      sNorm   = quot_q[N] ? scale_q : scale_q - SW'(1);
      kVal    = sNorm >>> ES;
      eBits   = sNorm[ES-1:0];
      term    = kVal[SW-1];
      runLen  = term ? -kVal : kVal + SW'(1);
      bufWord = {term, eBits, fracN, {(N-1){1'b0}}};
      shifted = term ? (bufWord >> runLen) : ~((~bufWord) >> runLen);
      body    = (N-1)'(shifted >> (L - N + 1));
      if (sNorm > MaxScale)      magWord = MaxPosWord;
      else if (sNorm < MinScale) magWord = MinPosWord;
      else                       magWord = {1'b0, body};
      encoded = sign_q ? -magWord : magWord;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         scale_q <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         quot_q  <= '0;
         cnt_q   <= '0;
         nar_q   <= 1'b0;
         zero_q  <= 1'b0;
         dz_q    <= 1'b0;
         res_q   <= '0;
         resDz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sign_q  <= sign_d;
         scale_q <= scale_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         quot_q  <= quot_d;
         cnt_q   <= cnt_d;
         nar_q   <= nar_d;
         zero_q  <= zero_d;
         dz_q    <= dz_d;
         res_q   <= res_d;
         resDz_q <= resDz_d;
      end
   end

   // Special cases are only flagged in DECODE; the datapath still runs the full
   // division so latency never depends on operand values.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sign_d  = sign_q;
      scale_d = scale_q;
      rem_d   = rem_q;
      div_d   = div_q;
      quot_d  = quot_q;
      cnt_d   = cnt_q;
      nar_d   = nar_q;
      zero_d  = zero_q;
      dz_d    = dz_q;
      res_d   = res_q;
      resDz_d = resDz_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               state_d = DECODE;
            end
         end
         DECODE: begin
            sign_d  = aSign ^ bSign;
            scale_d = aScale - bScale;
            rem_d   = {1'b0, aMant};
            div_d   = bMant;
            quot_d  = '0;
            cnt_d   = '0;
            dz_d    = bZero;
            nar_d   = bZero | aNar | bNar;
            zero_d  = aZero;
            state_d = DIVIDE;
         end
         DIVIDE: begin
            rem_d  = {remSub, 1'b0};
            quot_d = {quot_q[N-1:0], geq};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(N)) state_d = ENCODE;
         end
         ENCODE: begin
            if (nar_q)       res_d = NarWord;
            else if (zero_q) res_d = '0;
            else             res_d = encoded;
            resDz_d = dz_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign q           = res_q;
   assign div_by_zero = resDz_q;

endmodule

// File: doc/posit_divider.md
POSIT_DIVIDER -- requirements
Module: posit_divider

Interface
REQ-001 Parameter N, default 16, is the posit word width in bits.
REQ-002 Parameter ES, default 2, is the exponent field width in bits.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operands a, b present.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a  in  N  dividend posit, two's-complement encoded.
REQ-008 b  in  N  divisor posit, two's-complement encoded.
REQ-009 out_valid  out  1  quotient q valid.
REQ-010 out_ready  in  1  consumer accepts q.
REQ-011 q  out  N  quotient posit a/b.
REQ-012 div_by_zero  out  1  set with q when b was zero; qualified by out_valid.

Function
REQ-013 Operands are accepted on the edge where in_valid && in_ready; a and b are captured into internal registers at that edge.
REQ-014 in_ready is 1 only in state IDLE; the block holds one operation at a time.
REQ-015 The FSM has states IDLE, DECODE, DIVIDE, ENCODE, DONE: IDLE->DECODE on accept; DECODE->DIVIDE after 1 cycle; DIVIDE->ENCODE after exactly N+1 cycles; ENCODE->DONE after 1 cycle; DONE->IDLE on out_valid && out_ready.
REQ-016 Latency is fixed for all operand values: out_valid rises N+3 cycles after the accepting edge (19 for N=16).
REQ-017 out_valid is 1 only in DONE; q and div_by_zero hold stable while out_valid && !out_ready.
REQ-018 in_ready rises the cycle after the output handshake; no back-to-back overlap.
REQ-019 Decode: negative operands are two's-complemented to magnitude; regime run length gives k; scale = k*2^ES + exponent; fraction left-aligned with hidden 1, exponent/fraction bits truncated by the regime are zero.
REQ-020 Result sign = sign(a) XOR sign(b); result scale = scale(a) - scale(b), signed, width sufficient for +/-2*(N-2)*2^ES.
REQ-021 DIVIDE performs restoring division of the two N-bit mantissas, one quotient bit per cycle, producing N+1 quotient bits.
REQ-022 If the quotient integer bit is 0, the quotient shifts left by 1 and the result scale decrements by 1.
REQ-023 ENCODE rebuilds regime, exponent and fraction from scale and quotient; bits beyond N are truncated (round toward zero); a negative result is two's-complemented.
REQ-024 Magnitude saturation: result scale above maxpos scale yields maxpos (0x7FFF for N=16); below minpos scale yields minpos (0x0001); a nonzero quotient is never encoded as zero or NaR.
REQ-025 Special cases (outcome flagged in DECODE, latency unchanged): b == 0 -> q = NaR (1 followed by N-1 zeros), div_by_zero = 1; a or b NaR -> q = NaR, div_by_zero = 0; a == 0 with b nonzero and not NaR -> q = 0.
REQ-026 div_by_zero is 0 for every case not covered by b == 0.

Reset
REQ-027 While reset is high at an edge: state = IDLE, q = 0, div_by_zero = 0, out_valid = 0, operand/working registers = 0; in_ready = 1 on the first cycle after reset deasserts.
REQ-028 Reset asserted mid-operation (any state) aborts the operation; no out_valid is produced for it.

Structure
REQ-029 Shared package posit_pkg holds N, ES defaults, the FSM state enum, and constants ZERO, NAR, MAXPOS, MINPOS (derived from N).
REQ-030 One sub-module posit_decode (word -> sign, scale, mantissa, is_zero, is_nar) is instantiated twice; division and encoding reside in posit_divider.

Verification (N=16, ES=2)
REQ-031 a=0x4C00 (3.0), b=0x4400 (1.5) -> q=0x4800 (2.0), div_by_zero=0, out_valid exactly 19 cycles after accept.
REQ-032 a=0xC000 (-1.0), b=0x4800 (2.0) -> q=0xC800 (-0.5); a=0x4000, b=0x4800 -> q=0x3800 (0.5).
REQ-033 a=0x4000, b=0x0000 -> q=0x8000, div_by_zero=1; a=0x0000, b=0x4000 -> q=0x0000; a=0x8000, b=0x4000 -> q=0x8000, div_by_zero=0.
REQ-034 a=0x7FFF, b=0x0001 -> q=0x7FFF (saturated); a=0x0001, b=0x7FFF -> q=0x0001.
REQ-035 Hold out_ready=0 for 5 cycles after out_valid -> q stable, in_ready=0 throughout; then 1-cycle out_ready -> in_ready=1 the next cycle.
REQ-036 Assert reset during DIVIDE cycle 5 -> next cycle out_valid=0, q=0, in_ready=1; a subsequent operation completes with the correct result.
